// File: rtl/matrix_operand_loader_if.sv
// matrix_operand_loader_if: element stream in, packed operand pair out.
// master: upstream/multiplier side (drives clear, elem_valid, elem_data, mat_ack).
// slave:  the loader (drives elem_ready, mat_a, mat_b, mat_valid, range_err, timeout_err, elem_count).
interface matrix_operand_loader_if;
    logic       clear;
    logic       elem_valid;
    logic [1:0] elem_data;
    logic       elem_ready;
    logic [7:0] mat_a;
    logic [7:0] mat_b;
    logic       mat_valid;
    logic       mat_ack;
    logic       range_err;
    logic       timeout_err;
    logic [2:0] elem_count;
    modport master (
        output clear, elem_valid, elem_data, mat_ack,
        input  elem_ready, mat_a, mat_b, mat_valid, range_err, timeout_err, elem_count
    );
    modport slave (
        input  clear, elem_valid, elem_data, mat_ack,
        output elem_ready, mat_a, mat_b, mat_valid, range_err, timeout_err, elem_count
    );
endinterface

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: packs eight range-checked 2-bit elements into 2x2 operand words for the multiplier.
// Ports: clk, rst_n (async active-low), bus (slave modport: element stream, operand pair, error flags, count).
module matrix_operand_loader #(
    parameter int IDLE_TIMEOUT = 255
) (
    input logic clk,
    input logic rst_n,
    matrix_operand_loader_if.slave bus
);
    typedef enum logic {LOAD = 1'b0, PRESENT = 1'b1} state_t;
    state_t state, state_n;
    logic [13:0] staging;
    logic [7:0] mat_a, mat_b;
    logic [2:0] elem_count;
    logic [15:0] timer;
    logic err_seen, range_err, timeout_err;
    logic hs, illegal, last, drop_range, go_present, idle_expire;
    assign hs          = state == LOAD && bus.elem_valid;
    assign illegal     = bus.elem_data == 2'b10;
    assign last        = elem_count == 3'd7;
    assign drop_range  = hs && last && (err_seen || illegal);
    assign go_present  = hs && last && !drop_range;
    // Fires on the idle cycle that brings the timer up to IDLE_TIMEOUT.
    assign idle_expire = state == LOAD && elem_count != 3'd0 && !hs && timer == 16'(IDLE_TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_n;
    end
    always_comb begin
        state_n = state;
        state_n = bus.clear ? LOAD :
                  go_present ? PRESENT :
                  (state == PRESENT && bus.mat_ack) ? LOAD : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging     <= '0;
            mat_a       <= '0;
            mat_b       <= '0;
            elem_count  <= '0;
            timer       <= '0;
            err_seen    <= 1'b0;
            range_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else if (bus.clear) begin
            elem_count  <= '0;
            timer       <= '0;
            err_seen    <= 1'b0;
            range_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else if (hs) begin
            timer <= '0;
            if (elem_count == 3'd0) begin
                range_err   <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (last) begin
                elem_count <= '0;
                err_seen   <= 1'b0;
                if (drop_range) begin
                    range_err   <= 1'b1;
                    timeout_err <= 1'b0;
                end else begin
                    // b22 is taken straight from the bus; it never lands in staging.
                    mat_a <= staging[7:0];
                    mat_b <= {bus.elem_data, staging[13:8]};
                end
            end else begin
                staging[{elem_count, 1'b0} +: 2] <= bus.elem_data;
                elem_count <= elem_count + 3'd1;
                err_seen   <= err_seen | illegal;
            end
        end else if (idle_expire) begin
            elem_count  <= '0;
            timer       <= '0;
            err_seen    <= 1'b0;
            timeout_err <= 1'b1;
            range_err   <= 1'b0;
        end else if (state == LOAD && elem_count != 3'd0) begin
            timer <= timer + 16'd1;
        end
    end
    assign bus.elem_ready  = state == LOAD;
    assign bus.mat_valid   = state == PRESENT;
    assign bus.mat_a       = mat_a;
    assign bus.mat_b       = mat_b;
    assign bus.range_err   = range_err;
    assign bus.timeout_err = timeout_err;
    assign bus.elem_count  = elem_count;
endmodule
